mux_scanner: RTL
================

MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each data channel.
REQ-002 Parameter CHANNELS, default 8, number of input channels (2..256).
REQ-003 Parameter SEL_W, default 3, select/index width; SHALL satisfy 2**SEL_W >= CHANNELS.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 d  input  WIDTH*CHANNELS  channel k at bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel number, loaded by sel_load.
REQ-008 sel_load  input  1  load sel into the select register.
REQ-009 scan_start  input  1  begin an auto-scan from channel 0.
REQ-010 scan_cont  input  1  when 1, the scan wraps and runs continuously.
REQ-011 g_n  input  1  output enable, active-low.
REQ-012 y  inout  WIDTH  inverted sample; hi-Z when g_n=1.
REQ-013 w  inout  WIDTH  true sample; hi-Z when g_n=1.
REQ-014 valid  output  1  one-cycle pulse: the sample holds a newly selected channel.
REQ-015 ch  output  SEL_W  channel index of the current sample.
REQ-016 scan_busy  output  1  high while the scan FSM is in SCAN.

Function
REQ-017 The select register sel_q SHALL be updated only by sel_load or by scan stepping.
REQ-018 Every cycle, the sample register SHALL capture d[sel_q]; when sel_q >= CHANNELS, it SHALL capture all zeros.
REQ-019 ch SHALL be registered alongside the sample, equal to the sel_q value used for that capture.
REQ-020 Latency: sel_load at edge n SHALL make sel_q valid after n, the sample valid after n+1, and valid=1 during cycle n+1..n+2.
REQ-021 valid SHALL pulse for exactly one cycle on the first capture after any change or reload of sel_q, including a reload of an unchanged value.
REQ-022 valid SHALL remain 0 on continuous re-captures of an unchanged sel_q.
REQ-023 The FSM SHALL have two states: IDLE and SCAN.
REQ-024 IDLE->SCAN SHALL occur on scan_start=1 with sel_load=0, setting sel_q=0.
REQ-025 In SCAN, sel_q SHALL increment by 1 each cycle.
REQ-026 In SCAN at sel_q=CHANNELS-1: if scan_cont=1, sel_q SHALL wrap to 0 and stay in SCAN; otherwise the FSM SHALL return to IDLE with sel_q held at CHANNELS-1.
REQ-027 In SCAN, valid SHALL pulse once per channel, giving CHANNELS consecutive valid cycles per pass.
REQ-028 sel_load=1 in any state SHALL take priority, abort any scan to IDLE, and load sel.
REQ-029 scan_start during SCAN SHALL be ignored.
REQ-030 When g_n=0, y SHALL equal ~sample and w SHALL equal sample; g_n SHALL act combinationally, with no register stage.
REQ-031 g_n SHALL NOT affect sampling, the FSM, valid, or ch.

Reset
REQ-032 While reset_n=0 at an edge: sel_q=0, sample=0, ch=0, valid=0, scan_busy=0, FSM=IDLE.
REQ-033 Reset SHALL override sel_load and scan_start and abort any scan in progress.
REQ-034 During reset with g_n=0, y SHALL be all ones and w SHALL be all zeros.
REQ-035 The first cycle after reset release SHALL NOT produce a valid pulse unless sel_load or scan_start was asserted.

Configuration
REQ-036 Macro MUX_SCANNER_AUTOSCAN_EN defined: the scan FSM, scan_start, scan_cont and scan_busy SHALL behave as in REQ-023..REQ-029.
REQ-037 Macro MUX_SCANNER_AUTOSCAN_EN undefined: the ports SHALL remain, scan_start and scan_cont SHALL be ignored, scan_busy SHALL be tied to 0, and sel_q SHALL change only via sel_load.

Verification
REQ-038 Reset: reset_n=0 for 2 cycles with g_n=0 -> w=0, y=all ones, valid=0, ch=0, scan_busy=0.
REQ-039 Manual select: WIDTH=4, d channel 5=4'hA, sel=5, sel_load pulse at edge n -> w=4'hA, y=4'h5, ch=5, valid=1 for one cycle after n+1; valid stays 0 thereafter.
REQ-040 Single scan: CHANNELS=8, channel k=k, scan_start, scan_cont=0 -> 8 consecutive valid cycles with ch 0..7 and w=ch, then scan_busy=0 and ch holds 7.
REQ-041 Continuous scan and abort: scan_cont=1 -> ch sequence 6,7,0,1; sel_load with sel=3 mid-scan -> scan_busy=0 next cycle, ch=3 with one valid pulse.
REQ-042 Enable and range: CHANNELS=6, sel=7 loaded -> w=0, ch=7; g_n=1 -> y and w hi-Z while valid and ch continue updating.
REQ-043 Macro off: with MUX_SCANNER_AUTOSCAN_EN undefined, scan_start pulse -> sel_q unchanged, no valid pulse, scan_busy=0.

Source files
------------

// File: rtl/mux_scanner.sv
// Registered N-channel sampler with manual select and an optional auto-scan FSM.
// Define MUX_SCANNER_AUTOSCAN_EN to build the scan FSM; otherwise only sel_load moves the select.
module mux_scanner #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH*CHANNELS-1:0] d,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    input  logic                      scan_start,
    input  logic                      scan_cont,
    input  logic                      g_n,
    inout  wire  [WIDTH-1:0]          y,
    inout  wire  [WIDTH-1:0]          w,
    output logic                      valid,
    output logic [SEL_W-1:0]          ch,
    output logic                      scan_busy
);

    // Handshake: valid is a one-cycle strobe with no ready; the consumer must take
    // the sample (w/y, ch) in the cycle valid is high, there is no back-pressure.

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic             sel_wr;
    logic             sel_new_q;
    logic [WIDTH-1:0] mux_data;
    logic [WIDTH-1:0] sample_q;
    logic [SEL_W-1:0] ch_q;
    logic             valid_q;

    // Out-of-range selects fall through to zero.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                mux_data = d[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_SCANNER_AUTOSCAN_EN
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state_q;
    state_t state_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sel_wr  = 1'b0;
        if (sel_load) begin
            state_d = IDLE;
            sel_d   = sel;
            sel_wr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_start) begin
                        state_d = SCAN;
                        sel_d   = '0;
                        sel_wr  = 1'b1;
                    end
                end
                SCAN: begin
                    if (sel_q == LAST_CH) begin
                        if (scan_cont) begin
                            sel_d  = '0;
                            sel_wr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sel_d  = sel_q + SEL_W'(1);
                        sel_wr = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // scan_busy is the FSM state itself (SCAN = 1).
    assign scan_busy = (state_q == SCAN);
`else
    logic unused_scan_inputs;
    assign unused_scan_inputs = &{1'b0, scan_start, scan_cont, LAST_CH};

    always_comb begin
        sel_d  = sel_load ? sel : sel_q;
        sel_wr = sel_load;
    end

    assign scan_busy = 1'b0;
`endif

    // sel_new_q marks that sel_q was written at the last edge, so the next
    // capture is the first one of that selection and raises valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel_q     <= '0;
            sel_new_q <= 1'b0;
            sample_q  <= '0;
            ch_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            sel_new_q <= sel_wr;
            sample_q  <= mux_data;
            ch_q      <= sel_q;
            valid_q   <= sel_new_q;
        end
    end

    assign valid = valid_q;
    assign ch    = ch_q;

    // Output enable is purely combinational; it never touches the sampled state.
    assign y = g_n ? {WIDTH{1'bz}} : ~sample_q;
    assign w = g_n ? {WIDTH{1'bz}} : sample_q;

endmodule
